// File: rtl/sync_timing_rx_if.sv
// Sync/timing bundle between a sync source plus capture logic (master)
// and the timing receiver (slave).
interface sync_timing_rx_if;
   logic        h_sync;
   logic        v_sync;
   logic [10:0] h_pos;
   logic [10:0] v_pos;
   logic        active;
   logic        locked;
   logic        frame_start;
   logic        sync_err;
   logic [10:0] line_len;
   logic [10:0] frame_lines;

   modport master (
      output h_sync, v_sync,
      input  h_pos, v_pos, active, locked, frame_start, sync_err,
             line_len, frame_lines
   );

   modport slave (
      input  h_sync, v_sync,
      output h_pos, v_pos, active, locked, frame_start, sync_err,
             line_len, frame_lines
   );
endinterface

// File: rtl/sync_timing_rx.sv
// Receive-side video timing recovery: synchronises H/V sync, measures line
// and frame periods, tracks lock and produces pixel/line coordinates plus an
// active-video window enable.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_SEARCH  | waiting for a V strobe, no checking, no error reporting
// ACQUIRE    | checking frames, counting consecutive good ones, errors pulse
// ST_LOCKED  | timing locked, first line/frame fault drops back to SEARCH
module sync_timing_rx #(
   parameter int unsigned H_TOTAL     = 800,
   parameter int unsigned V_TOTAL     = 528,
   parameter int unsigned H_ACT_START = 144,
   parameter int unsigned H_ACTIVE    = 640,
   parameter int unsigned V_ACT_START = 35,
   parameter int unsigned V_ACTIVE    = 480,
   parameter int unsigned LOCK_FRAMES = 2
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   sync_timing_rx_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_SEARCH  = 2'd0,
      ST_ACQUIRE = 2'd1,
      ST_LOCKED  = 2'd2
   } state_t;

   localparam logic [11:0] LP_H_TOT = 12'(H_TOTAL);
   localparam logic [11:0] LP_V_TOT = 12'(V_TOTAL);
   localparam logic [10:0] LP_H_TO  = 11'(H_TOTAL - 1);
   localparam logic [10:0] LP_HA_LO = 11'(H_ACT_START);
   localparam logic [10:0] LP_HA_HI = 11'(H_ACT_START + H_ACTIVE);
   localparam logic [10:0] LP_VA_LO = 11'(V_ACT_START);
   localparam logic [10:0] LP_VA_HI = 11'(V_ACT_START + V_ACTIVE);
   localparam logic [3:0]  LP_LOCK  = 4'(LOCK_FRAMES);
   localparam logic [10:0] LP_SAT   = 11'h7FF;

   logic        r_hs_meta, r_hs_sync, r_hs_dly, r_hs_strb;
   logic        r_vs_meta, r_vs_sync, r_vs_dly, r_vs_strb;
   logic [10:0] r_h_cnt, r_v_cnt;
   logic [10:0] r_line_len, r_frame_lines;
   logic        r_h_seen;
   logic        r_frame_start, r_sync_err;
   logic [3:0]  r_good_cnt;
   logic        r_bad_frame;
   state_t      r_state;

   state_t      w_state_nxt;
   logic [3:0]  w_good_cnt_nxt;
   logic        w_bad_frame_nxt;
   logic        w_sync_err_nxt;
   logic        w_search_entry;

   logic        w_hs, w_vs;
   logic [11:0] w_h_inc, w_v_inc;
   logic [10:0] w_h_sat, w_v_sat;
   logic [10:0] w_frame_lines_new;
   logic        w_line_mismatch, w_timeout, w_line_bad;
   logic        w_frame_good;
   logic        w_locked;

   // Two-flop synchronisers, edge detect and registered rising-edge strobes.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_hs_meta <= 1'b0;
         r_hs_sync <= 1'b0;
         r_hs_dly  <= 1'b0;
         r_hs_strb <= 1'b0;
         r_vs_meta <= 1'b0;
         r_vs_sync <= 1'b0;
         r_vs_dly  <= 1'b0;
         r_vs_strb <= 1'b0;
      end else begin
         r_hs_meta <= bus.h_sync;
         r_hs_sync <= r_hs_meta;
         r_hs_dly  <= r_hs_sync;
         r_hs_strb <= r_hs_sync & ~r_hs_dly;
         r_vs_meta <= bus.v_sync;
         r_vs_sync <= r_vs_meta;
         r_vs_dly  <= r_vs_sync;
         r_vs_strb <= r_vs_sync & ~r_vs_dly;
      end
   end

   assign w_hs = r_hs_strb;
   assign w_vs = r_vs_strb;

   assign w_h_inc = {1'b0, r_h_cnt} + 12'd1;
   assign w_v_inc = {1'b0, r_v_cnt} + 12'd1;
   assign w_h_sat = w_h_inc[11] ? LP_SAT : w_h_inc[10:0];
   assign w_v_sat = w_v_inc[11] ? LP_SAT : w_v_inc[10:0];

   // A coincident H strobe belongs to the frame that is ending.
   assign w_frame_lines_new = w_hs ? w_v_sat : r_v_cnt;

   // A missing H strobe is flagged once, as the counter steps onto H_TOTAL.
   assign w_line_mismatch = w_hs & r_h_seen & (w_h_inc != LP_H_TOT);
   assign w_timeout       = ~w_hs & (r_h_cnt == LP_H_TO) & (r_state != ST_SEARCH);
   assign w_line_bad      = w_line_mismatch | w_timeout;
   assign w_frame_good    = ({1'b0, w_frame_lines_new} == LP_V_TOT) &
                            ~r_bad_frame & ~w_line_bad;

   // Lock state register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_SEARCH;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state, good-frame counting and error pulse decisions.
   always_comb begin
      w_state_nxt     = r_state;
      w_good_cnt_nxt  = r_good_cnt;
      w_bad_frame_nxt = r_bad_frame;
      w_sync_err_nxt  = 1'b0;
      w_search_entry  = 1'b0;
      case (r_state)
         ST_SEARCH: begin
            if (w_vs) begin
               w_state_nxt     = ST_ACQUIRE;
               w_good_cnt_nxt  = 4'd0;
               w_bad_frame_nxt = 1'b0;
            end
         end
         ST_ACQUIRE: begin
            if (w_vs) begin
               w_bad_frame_nxt = 1'b0;
               if (w_frame_good) begin
                  w_good_cnt_nxt = r_good_cnt + 4'd1;
                  if ((r_good_cnt + 4'd1) == LP_LOCK) begin
                     w_state_nxt = ST_LOCKED;
                  end
               end else begin
                  w_good_cnt_nxt = 4'd0;
                  w_sync_err_nxt = 1'b1;
               end
            end else if (w_line_bad) begin
               w_bad_frame_nxt = 1'b1;
            end
         end
         ST_LOCKED: begin
            if (w_line_bad || (w_vs && !w_frame_good)) begin
               w_state_nxt     = ST_SEARCH;
               w_good_cnt_nxt  = 4'd0;
               w_bad_frame_nxt = 1'b0;
               w_sync_err_nxt  = 1'b1;
               w_search_entry  = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_SEARCH;
         end
      endcase
   end

   // Frame bookkeeping that travels with the state machine.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_good_cnt  <= 4'd0;
         r_bad_frame <= 1'b0;
         r_sync_err  <= 1'b0;
      end else begin
         r_good_cnt  <= w_good_cnt_nxt;
         r_bad_frame <= w_bad_frame_nxt;
         r_sync_err  <= w_sync_err_nxt;
      end
   end

   // Pixel and line counters; V strobe takes priority over a coincident H.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_h_cnt <= 11'd0;
         r_v_cnt <= 11'd0;
      end else begin
         r_h_cnt <= w_hs ? 11'd0 : w_h_sat;
         if (w_vs) begin
            r_v_cnt <= 11'd0;
         end else if (w_hs) begin
            r_v_cnt <= w_v_sat;
         end
      end
   end

   // The first H strobe after reset or loss of lock only arms line checking.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_h_seen <= 1'b0;
      end else if (w_search_entry) begin
         r_h_seen <= 1'b0;
      end else if (w_hs) begin
         r_h_seen <= 1'b1;
      end
   end

   // Period measurements and frame start pulse.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_line_len    <= 11'd0;
         r_frame_lines <= 11'd0;
         r_frame_start <= 1'b0;
      end else begin
         if (w_hs && r_h_seen) begin
            r_line_len <= w_h_sat;
         end
         if (w_vs) begin
            r_frame_lines <= w_frame_lines_new;
         end
         r_frame_start <= w_vs;
      end
   end

   assign w_locked = (r_state == ST_LOCKED);

   assign bus.h_pos       = r_h_cnt;
   assign bus.v_pos       = r_v_cnt;
   assign bus.locked      = w_locked;
   assign bus.active      = w_locked &&
                            (r_h_cnt >= LP_HA_LO) && (r_h_cnt < LP_HA_HI) &&
                            (r_v_cnt >= LP_VA_LO) && (r_v_cnt < LP_VA_HI);
   assign bus.frame_start = r_frame_start;
   assign bus.sync_err    = r_sync_err;
   assign bus.line_len    = r_line_len;
   assign bus.frame_lines = r_frame_lines;

endmodule

// File: tb/tb_sync_timing_rx.sv
// Bench for sync_timing_rx with a reduced raster so whole frames stay short.
module tb_sync_timing_rx;

   localparam int HT  = 40;
   localparam int VT  = 12;
   localparam int HAS = 8;
   localparam int HA  = 24;
   localparam int VAS = 2;
   localparam int VA  = 8;
   localparam int LF  = 2;

   localparam int M_SEARCH = 0;
   localparam int M_ACQ    = 1;
   localparam int M_LOCK   = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   bit   rst_cmd = 1'b0;

   sync_timing_rx_if bus ();

   sync_timing_rx #(
      .H_TOTAL(HT), .V_TOTAL(VT), .H_ACT_START(HAS), .H_ACTIVE(HA),
      .V_ACT_START(VAS), .V_ACTIVE(VA), .LOCK_FRAMES(LF)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model: pin history plus rule-level timing state
   bit hist_h[5];
   bit hist_v[5];
   int m_h, m_v, m_seen, m_st, m_good, m_bad, m_llen, m_flines, m_fs, m_err;

   // scenario observations
   int fs_cnt, err_cnt, lock_at_fs, act_cnt;
   bit act_armed, first_in_frame, prev_active, prev_locked;
   int err_llen, err_hpos, err_locked;

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int sat(input int x);
      return (x > 2047) ? 2047 : x;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 5; i++) begin
         hist_h[i] = 1'b0;
         hist_v[i] = 1'b0;
      end
      m_h = 0; m_v = 0; m_seen = 0; m_st = M_SEARCH; m_good = 0; m_bad = 0;
      m_llen = 0; m_flines = 0; m_fs = 0; m_err = 0;
   endtask

   // One clock edge: pin sampled now produces its strobe three edges later.
   task automatic model_step(input bit ph, input bit pv);
      bit hs, vs, lb, fgood, err, clr;
      int fl;
      for (int i = 4; i > 0; i--) begin
         hist_h[i] = hist_h[i-1];
         hist_v[i] = hist_v[i-1];
      end
      hist_h[0] = ph;
      hist_v[0] = pv;
      hs = hist_h[3] && !hist_h[4];
      vs = hist_v[3] && !hist_v[4];
      lb = (hs && m_seen != 0 && (m_h + 1 != HT)) ||
           (!hs && (m_h + 1 == HT) && m_st != M_SEARCH);
      fl = sat(m_v + (hs ? 1 : 0));
      fgood = vs && (fl == VT) && (m_bad == 0) && !lb;
      err = 1'b0;
      clr = 1'b0;
      if (m_st == M_SEARCH) begin
         if (vs) begin
            m_st = M_ACQ; m_good = 0; m_bad = 0;
         end
      end else if (m_st == M_ACQ) begin
         if (vs) begin
            m_bad = 0;
            if (fgood) begin
               m_good++;
               if (m_good == LF) m_st = M_LOCK;
            end else begin
               m_good = 0; err = 1'b1;
            end
         end else if (lb) begin
            m_bad = 1;
         end
      end else begin
         if (lb || (vs && !fgood)) begin
            m_st = M_SEARCH; m_good = 0; m_bad = 0; err = 1'b1; clr = 1'b1;
         end
      end
      if (hs && m_seen != 0) m_llen = sat(m_h + 1);
      if (vs) m_flines = fl;
      m_fs  = vs ? 1 : 0;
      m_err = err ? 1 : 0;
      m_h   = hs ? 0 : sat(m_h + 1);
      m_v   = vs ? 0 : (hs ? sat(m_v + 1) : m_v);
      m_seen = clr ? 0 : (hs ? 1 : m_seen);
   endtask

   task automatic compare_all();
      int exp_act;
      exp_act = (m_st == M_LOCK && m_h >= HAS && m_h < HAS + HA &&
                 m_v >= VAS && m_v < VAS + VA) ? 1 : 0;
      chk("h_pos",       int'(bus.h_pos),       m_h);
      chk("v_pos",       int'(bus.v_pos),       m_v);
      chk("active",      int'(bus.active),      exp_act);
      chk("locked",      int'(bus.locked),      (m_st == M_LOCK) ? 1 : 0);
      chk("frame_start", int'(bus.frame_start), m_fs);
      chk("sync_err",    int'(bus.sync_err),    m_err);
      chk("line_len",    int'(bus.line_len),    m_llen);
      chk("frame_lines", int'(bus.frame_lines), m_flines);
   endtask

   task automatic monitor();
      if (bus.frame_start) begin
         fs_cnt++;
         if (act_armed) chk("active_per_frame", act_cnt, HA * VA);
         act_cnt = 0;
         act_armed = bus.locked;
         first_in_frame = 1'b1;
      end
      if (bus.sync_err) begin
         err_cnt++;
         act_armed = 1'b0;
         err_llen = int'(bus.line_len);
         err_hpos = int'(bus.h_pos);
         err_locked = int'(bus.locked);
      end
      if (bus.active) begin
         act_cnt++;
         if (!prev_active) begin
            chk("first_active_h", int'(bus.h_pos), HAS);
            if (first_in_frame) begin
               chk("first_active_v", int'(bus.v_pos), VAS);
               first_in_frame = 1'b0;
            end
         end
      end
      if (bus.locked && !prev_locked) begin
         lock_at_fs = fs_cnt;
         chk("lock_on_vs", int'(bus.frame_start), 1);
      end
      prev_active = bus.active;
      prev_locked = bus.locked;
   endtask

   task automatic drive_cycle(input bit h, input bit v);
      @(negedge clk);
      bus.h_sync = h;
      bus.v_sync = v;
      rst_n = rst_cmd;
      @(posedge clk);
      if (rst_n) model_step(h, v);
      else model_reset();
      #1;
      compare_all();
      monitor();
   endtask

   // k = V_SYNC rise offset within line 0; 0 makes it coincide with H_SYNC.
   task automatic run_frame(input int k, input int bad_line, input int bad_len,
                            input int nlines);
      int len, hw;
      bit h, v;
      for (int ln = 0; ln < nlines; ln++) begin
         len = (ln == bad_line) ? bad_len : HT;
         hw = $urandom_range(4, 1);
         for (int c = 0; c < len; c++) begin
            h = (c < hw);
            v = (ln == 0 && c >= k) || (ln == 1) || (ln == 2 && c < k);
            drive_cycle(h, v);
         end
      end
   endtask

   task automatic async_reset();
      #2;
      rst_n = 1'b0;
      rst_cmd = 1'b0;
      #1;
      model_reset();
      compare_all();
      chk("rst_locked", int'(bus.locked), 0);
      chk("rst_h_pos",  int'(bus.h_pos), 0);
      act_armed = 1'b0;
      prev_locked = 1'b0;
      prev_active = 1'b0;
   endtask

   initial begin
      int e0, bl, blen;
      bus.h_sync = 1'b0;
      bus.v_sync = 1'b0;
      model_reset();
      fs_cnt = 0; err_cnt = 0; lock_at_fs = -1; act_cnt = 0;
      act_armed = 1'b0; first_in_frame = 1'b0;
      prev_active = 1'b0; prev_locked = 1'b0;
      #1;
      compare_all();
      repeat (3) drive_cycle(1'b0, 1'b0);
      rst_cmd = 1'b1;

      // nominal stream: lock on the third V strobe
      for (int f = 0; f < 5; f++) run_frame($urandom_range(HT - 5, 1), -1, 0, VT);
      chk("lock_at_vs_count", lock_at_fs, 3);
      chk("nominal_line_len", int'(bus.line_len), HT);
      chk("nominal_frame_lines", int'(bus.frame_lines), VT);
      chk("nominal_no_err", err_cnt, 0);

      // one short line while locked, then relock after three more V strobes
      e0 = err_cnt;
      run_frame($urandom_range(HT - 5, 1), 5, HT - 1, VT);
      chk("short_err_count", err_cnt - e0, 1);
      chk("short_err_line_len", err_llen, HT - 1);
      chk("short_err_unlocked", err_locked, 0);
      run_frame($urandom_range(HT - 5, 1), -1, 0, VT);
      run_frame($urandom_range(HT - 5, 1), -1, 0, VT);
      chk("short_not_yet_locked", int'(bus.locked), 0);
      run_frame($urandom_range(HT - 5, 1), -1, 0, VT);
      chk("short_relocked", int'(bus.locked), 1);

      // H_SYNC stuck low: timeout at H_TOTAL, then counter saturates
      e0 = err_cnt;
      repeat (2100) drive_cycle(1'b0, 1'b0);
      chk("timeout_err_count", err_cnt - e0, 1);
      chk("timeout_h_pos", err_hpos, HT);
      chk("timeout_unlocked", err_locked, 0);
      chk("h_pos_saturated", int'(bus.h_pos), 2047);

      // V strobe coincident with H strobe
      for (int f = 0; f < 4; f++) run_frame(0, -1, 0, VT);
      chk("coincident_locked", int'(bus.locked), 1);
      chk("coincident_frame_lines", int'(bus.frame_lines), VT);

      // randomized line-length faults
      for (int f = 0; f < 8; f++) begin
         bl = ($urandom_range(1, 0) == 1) ? int'($urandom_range(VT - 1, 0)) : -1;
         blen = HT + int'($urandom_range(4, 0)) - 2;
         run_frame($urandom_range(HT - 5, 0), bl, blen, VT);
      end

      // reset in mid-frame while locked
      for (int f = 0; f < 3; f++) run_frame($urandom_range(HT - 5, 1), -1, 0, VT);
      chk("pre_reset_locked", int'(bus.locked), 1);
      run_frame($urandom_range(HT - 5, 1), -1, 0, VT / 2);
      async_reset();
      repeat (3) drive_cycle(1'b0, 1'b0);
      rst_cmd = 1'b1;
      run_frame($urandom_range(HT - 5, 1), -1, 0, VT);
      run_frame($urandom_range(HT - 5, 1), -1, 0, VT);
      chk("post_reset_not_locked", int'(bus.locked), 0);
      run_frame($urandom_range(HT - 5, 1), -1, 0, VT);
      chk("post_reset_relocked", int'(bus.locked), 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
